// File: rtl/rsa256_core.sv
// rsa256_core: y^d mod N via right-to-left binary exponentiation on
// Montgomery products (R = 2^W). Fed by the RSA256 Avalon wrapper; the result
// comes back with a one-cycle o_finished pulse.
// Optional build macro RSA256_CORE_MSB_EXIT_EN: stop after the highest set bit
// of d (data-dependent latency). Without it every run scans all W exponent bits.
module rsa256_core #(
  parameter int unsigned W = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_d,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_a_pow_d,
  output logic         o_finished
);

  localparam int unsigned CW = $clog2(W + 1);
  localparam int unsigned IW = $clog2(W);
  localparam int unsigned RW = W + 2;

  typedef enum logic [1:0] {IDLE, PREP, MONT, DONE} state_t;

  state_t        state;
  logic [W-1:0]  d_r;
  logic [W-1:0]  n_r;
  logic [W-1:0]  t_r;
  logic [W-1:0]  m_r;
  logic [RW-1:0] r1;
  logic [RW-1:0] r2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] bit_idx;

  logic [RW-1:0] n_ext;
  logic [W-1:0]  dbl;
  logic [RW-1:0] nxt1;
  logic [RW-1:0] nxt2;
  logic [W-1:0]  fin1;
  logic [W-1:0]  fin2;
  logic          last_bit;

  assign n_ext = {2'b00, n_r};

  // One radix-2 Montgomery iteration: r <- (r + aj*b + q*N) / 2
  function automatic logic [RW-1:0] mp_step(input logic [RW-1:0] r,
                                            input logic          aj,
                                            input logic [W-1:0]  b,
                                            input logic [W-1:0]  n);
    logic [RW:0] s;
    s = {1'b0, r} + (aj ? {3'b000, b} : '0);
    if (s[0]) s = s + {3'b000, n};
    return s[RW:1];
  endfunction

  // Single conditional subtraction, result narrowed to the operand width
  function automatic logic [W-1:0] cond_sub(input logic [RW-1:0] v,
                                            input logic [RW-1:0] m);
    return W'((v >= m) ? (v - m) : v);
  endfunction

  // Doubling step of the conversion t = y*2^W mod N
  always_comb begin
    dbl = cond_sub({1'b0, t_r, 1'b0}, n_ext);
  end

  // Two Montgomery units in parallel: MP(m,t) and MP(t,t)
  always_comb begin
    nxt1 = mp_step(r1, m_r[cnt[IW-1:0]], t_r, n_r);
    nxt2 = mp_step(r2, t_r[cnt[IW-1:0]], t_r, n_r);
    fin1 = cond_sub(r1, n_ext);
    fin2 = cond_sub(r2, n_ext);
  end

`ifdef RSA256_CORE_MSB_EXIT_EN
  logic [CW-1:0] k_last;
  logic [CW-1:0] msb_idx;

  // Position of the highest set bit of the captured exponent
  always_comb begin
    msb_idx = '0;
    for (int unsigned i = 0; i < W; i++) begin
      if (d_r[i]) msb_idx = CW'(i);
    end
  end

  assign last_bit = (bit_idx == k_last);
`else
  assign last_bit = (bit_idx == CW'(W - 1));
`endif

  // Control FSM with all working registers and registered outputs
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      d_r        <= '0;
      n_r        <= '0;
      t_r        <= '0;
      m_r        <= '0;
      r1         <= '0;
      r2         <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      o_a_pow_d  <= '0;
      o_finished <= 1'b0;
`ifdef RSA256_CORE_MSB_EXIT_EN
      k_last     <= '0;
`endif
    end else begin
      o_finished <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start) begin
            d_r   <= i_d;
            n_r   <= i_n;
            t_r   <= i_a;
            cnt   <= '0;
            state <= PREP;
          end
        end

        PREP: begin
          // count 0 is the pass-through step, counts 1..W double
          if (cnt != '0) t_r <= dbl;
          if (cnt == CW'(W)) begin
            cnt     <= '0;
            bit_idx <= '0;
            m_r     <= W'(1);
            r1      <= '0;
            r2      <= '0;
`ifdef RSA256_CORE_MSB_EXIT_EN
            k_last  <= msb_idx;
            state   <= (d_r == '0) ? DONE : MONT;
`else
            state   <= MONT;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        MONT: begin
          if (cnt == CW'(W)) begin
            // final-subtraction cycle: commit both products, clear accumulators
            if (d_r[bit_idx[IW-1:0]]) m_r <= fin1;
            t_r <= fin2;
            r1  <= '0;
            r2  <= '0;
            cnt <= '0;
            if (last_bit) state <= DONE;
            else          bit_idx <= bit_idx + 1'b1;
          end else begin
            r1  <= nxt1;
            r2  <= nxt2;
            cnt <= cnt + 1'b1;
          end
        end

        DONE: begin
          o_a_pow_d  <= m_r;
          o_finished <= 1'b1;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa256_core.sv
// tb_rsa256_core: randomized and directed checks of rsa256_core at W=8 against
// a plain-arithmetic modular-exponentiation and latency model.
module tb_rsa256_core;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] d;
  logic [W-1:0] n;
  logic [W-1:0] res;
  logic         fin;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  bit           preloaded = 1'b0;
  logic [W-1:0] nx_y;
  logic [W-1:0] nx_d;
  logic [W-1:0] nx_n;

  always #5 clk = ~clk;

  rsa256_core #(.W(W)) dut (
    .i_clk      (clk),
    .i_rst      (rst_n),
    .i_start    (start),
    .i_a        (a),
    .i_d        (d),
    .i_n        (n),
    .o_a_pow_d  (res),
    .o_finished (fin)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // y^e mod m by repeated multiplication
  function automatic int unsigned ref_pow(input int unsigned y, input int unsigned e,
                                          input int unsigned m);
    int unsigned r;
    r = 1 % m;
    for (int unsigned i = 0; i < e; i++) r = (r * y) % m;
    return r;
  endfunction

  // Cycle of the o_finished pulse, counted from the accepting edge
  function automatic int unsigned ref_lat(input int unsigned e);
    int unsigned k;
`ifdef RSA256_CORE_MSB_EXIT_EN
    k = 0;
    while ((e >> k) != 0) k++;
`else
    k = W;
`endif
    return (W + 1) + k * (W + 1) + 1;
  endfunction

  // One operation; chain preloads nx_* during DONE, poke re-pulses i_start mid-run
  task automatic run_op(input string tag, input logic [W-1:0] y, input logic [W-1:0] e,
                        input logic [W-1:0] m, input bit chain, input bit poke);
    int unsigned  lat;
    int unsigned  expv;
    int unsigned  c;
    bit           done;
    logic [W-1:0] prev;
    lat  = ref_lat(e);
    expv = ref_pow(y, e, m);
    prev = res;
    c    = 0;
    done = 1'b0;
    if (!preloaded) begin
      a = y; d = e; n = m; start = 1'b1;
    end
    preloaded = 1'b0;
    @(posedge clk); #1;
    a = W'($urandom); d = W'($urandom); n = W'($urandom);
    start = 1'b0;
    while (!done && c < lat + 20) begin
      start = poke && (c == 4 || (c == 39 && lat > 45));
      if (c == lat - 1) begin
        check({tag, " hold"}, res, prev);
        if (chain) begin
          a = nx_y; d = nx_d; n = nx_n; start = 1'b1; preloaded = 1'b1;
        end
      end
      @(posedge clk); #1;
      c++;
      if (fin) done = 1'b1;
    end
    check({tag, " lat"}, c, lat);
    check({tag, " res"}, res, expv);
    if (!chain) begin
      start = 1'b0;
      @(posedge clk); #1;
      check({tag, " pulse"}, fin, 1'b0);
      check({tag, " keep"}, res, expv);
    end
  endtask

  logic [W-1:0] ry[12];
  logic [W-1:0] rd[12];
  logic [W-1:0] rn[12];

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; d = '0; n = '0;
    #1;
    check("reset res", res, 0);
    check("reset fin", fin, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    run_op("tp1", 8'd5, 8'd3, 8'd13, 1'b0, 1'b0);
    run_op("tp2", 8'd7, 8'd0, 8'd11, 1'b0, 1'b0);
    nx_y = 8'd2; nx_d = 8'd10; nx_n = 8'd251;
    run_op("tp3a", 8'd0, 8'd200, 8'd251, 1'b1, 1'b0);
    run_op("tp3b", 8'd2, 8'd10, 8'd251, 1'b0, 1'b0);
    run_op("tp4", 8'd5, 8'd3, 8'd13, 1'b0, 1'b1);
    run_op("pre_rst", 8'd3, 8'd5, 8'd7, 1'b0, 1'b0);

    // reset in the middle of a run
    a = 8'd5; d = 8'd3; n = 8'd13; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    #1; rst_n = 1'b0; #1;
    check("rst res", res, 0);
    check("rst fin", fin, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst hold fin", fin, 0);
    @(negedge clk); rst_n = 1'b1;
    run_op("post_rst", 8'd5, 8'd3, 8'd13, 1'b0, 1'b0);

    // randomized operands, some back-to-back
    for (int i = 0; i < 12; i++) begin
      rn[i] = W'($urandom_range(1, 127) * 2 + 1);
      ry[i] = W'($urandom_range(0, int'(rn[i]) - 1));
      rd[i] = (i % 4 == 0) ? '0 : W'($urandom_range(0, 255));
    end
    for (int i = 0; i < 12; i++) begin
      bit ch;
      ch = (i % 3 != 2) && (i < 11);
      if (ch) begin
        nx_y = ry[i + 1]; nx_d = rd[i + 1]; nx_n = rn[i + 1];
      end
      run_op($sformatf("rnd%0d", i), ry[i], rd[i], rn[i], ch, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rsa256_core.md
# rsa256_core

Modular-exponentiation engine that sits directly downstream of the RSA256 Avalon wrapper. It receives ciphertext y, private exponent d and modulus N, and computes y^d mod N with right-to-left binary exponentiation over Montgomery products. It returns the plaintext with a one-cycle completion pulse, which the wrapper latches and streams back out over RS232.

## Interface
- W, 256, operand width in bits; must be ≥ 4.
- i_clk  in  1  clock; all state changes on its rising edge.
- i_rst  in  1  reset; asynchronous, active-low.
- i_start  in  1  start request; honoured only in IDLE.
- i_a  in  W  base y; requires y < N.
- i_d  in  W  exponent d.
- i_n  in  W  modulus N; must be odd and > 1.
- o_a_pow_d  out  W  result y^d mod N.
- o_finished  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, PREP, MONT, DONE.
- **IDLE**
  - On i_start=1, capture i_a, i_d and i_n into internal registers, then go to PREP.
  - Later input changes are ignored until the next accept.
- **PREP** (W+1 cycles): compute t = y·2^W mod N by shift-and-conditional-subtract.
  - Set t ← y, then repeat W+1 times: t ← 2t; if t ≥ N then t ← t−N.
  - The first step is a pass-through, so exactly W doublings occur.
  - Set m ← 1. Go to MONT.
- **MONT**: one pass per exponent bit i = 0, 1, …, K−1.
  - Each pass runs two parallel Montgomery units for W+1 cycles.
  - m' = MP(m,t) if d[i]=1, else m' = m. t' = MP(t,t).
  - MP(a,b) = a·b·2^−W mod N, computed in W radix-2 iterations: r ← (r + a_j·b + q·N)/2, with q = LSB of (r + a_j·b).
  - One final cycle applies: if r ≥ N then r ← r−N.
  - Intermediate registers are W+2 bits wide; no truncation before the final subtraction.
  - After bit K−1, go to DONE.
- **DONE** (1 cycle): load o_a_pow_d ← m, pulse o_finished, return to IDLE.
- K = W without the configuration macro; see Configuration for the alternative.
- Boundary rules:
  - i_start while not in IDLE is ignored, with no queuing.
  - i_start=1 during the DONE cycle is ignored. It is accepted on the following IDLE cycle if still high.
  - d = 0 gives 1. y = 0 with d ≠ 0 gives 0.
  - Behaviour for even N, N ≤ 1, or y ≥ N is unspecified, but the FSM must still terminate with the same latency.
  - Reset low at any time forces IDLE, clears all working registers, o_a_pow_d = 0 and o_finished = 0.

## Timing
- Reset values: o_a_pow_d = 0, o_finished = 0, state = IDLE.
- Cycle 0 is the edge where i_start is sampled in IDLE.
- o_finished is high for exactly one cycle at cycle L = (W+1) + K·(W+1) + 1.
  - Fixed K=W gives W=8: L = 82; W=256: L = 66050.
- o_a_pow_d changes only at the DONE edge and at reset. It holds its value until the next DONE.
- Back-to-back operation: the next start can be accepted 1 cycle after the o_finished cycle.

## Configuration
- Macro: RSA256_CORE_MSB_EXIT_EN.
- Defined:
  - K = (index of the highest set bit of the captured d) + 1, computed during PREP.
  - d = 0 gives K = 0: MONT is skipped and the block goes PREP→DONE with result 1.
  - Latency becomes data-dependent per the L formula.
- Undefined: K = W always, giving constant latency with no timing leak through d.

## Test plan
- W=8, y=5, d=3, N=13 → o_a_pow_d=8.
  - Without the macro: o_finished at cycle 82.
  - With the macro: o_finished at cycle 28.
- W=8, y=7, d=0, N=11 → result 1.
  - Latency 82 without the macro; 10 with it.
- W=8, y=0, d=200, N=251 → 0. Then immediately y=2, d=10, N=251 → 20 (1024 mod 251). Checks back-to-back starts and output hold between runs.
- W=8, y=5, d=3, N=13: pulse i_start again at cycles 5 and 40 → a single o_finished with result 8. Inputs changed after cycle 0 have no effect.
- Drive i_rst low at cycle 30 of a run → outputs 0 immediately and the FSM is in IDLE. A new start after release gives a correct result with full latency.
- W=256 with a known RSA vector (N, d, y) from the lab key set → result matches the golden plaintext and o_finished occurs at cycle 66050 (macro undefined).
